// File: rtl/factor_search_seq.sv
// Sequential factor search: finds the pair (d, q), smallest d first, with d*q == a
// and both factors in 2..2^NF-1, using an accumulated product instead of a multiplier.
module factor_search_seq #(
  parameter int NA = 12,
  parameter int NF = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NA-1:0] a,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          found,
  output logic [NF-1:0] i1,
  output logic [NF-1:0] i2
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [NF-1:0] CAND_MIN = NF'(2);
  localparam logic [NF-1:0] CAND_MAX = '1;
  localparam logic [NA-1:0] P_INIT   = NA'(4);

  state_t        state, state_n;
  logic [NA-1:0] a_reg, a_reg_n;
  logic [NA-1:0] p, p_n;
  logic [NF-1:0] d, d_n, q, q_n;
  logic [NF-1:0] i1_n, i2_n;
  logic          found_n;

  logic [NF-1:0] d_inc;
  logic [NA-1:0] p_adv;
  logic [NA-1:0] p_step;

  // p never exceeds (2^NF-1)^2, so NA >= 2*NF keeps every update in range.
  assign d_inc  = d + NF'(1);
  assign p_adv  = NA'(d_inc) << 1;
  assign p_step = p + NA'(d);

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // NOTE: every next-state variable takes its current value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    a_reg_n = a_reg;
    p_n     = p;
    d_n     = d;
    q_n     = q;
    found_n = found;
    i1_n    = i1;
    i2_n    = i2;
    case (state)
      IDLE: begin
        if (start) begin
          a_reg_n = a;
          d_n     = CAND_MIN;
          q_n     = CAND_MIN;
          p_n     = P_INIT;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (p == a_reg) begin
          found_n = 1'b1;
          i1_n    = d;
          i2_n    = q;
          state_n = DONE;
        end else if (p > a_reg || q == CAND_MAX) begin
          // Current divisor exhausted: move to the next one, or give up after the last.
          if (d == CAND_MAX) begin
            found_n = 1'b0;
            i1_n    = '0;
            i2_n    = '0;
            state_n = DONE;
          end else begin
            d_n = d_inc;
            q_n = CAND_MIN;
            p_n = p_adv;
          end
        end else begin
          q_n = q + NF'(1);
          p_n = p_step;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values computed from the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      p     <= '0;
      d     <= '0;
      q     <= '0;
      found <= 1'b0;
      i1    <= '0;
      i2    <= '0;
    end else begin
      state <= state_n;
      a_reg <= a_reg_n;
      p     <= p_n;
      d     <= d_n;
      q     <= q_n;
      found <= found_n;
      i1    <= i1_n;
      i2    <= i2_n;
    end
  end

endmodule

// File: tb/tb_factor_search_seq.sv
// Scoreboard bench for factor_search_seq: stimulus pushes reference results,
// a negedge monitor pops and compares them at each output handshake.
module tb_factor_search_seq;

  localparam int NA = 12;
  localparam int NF = 6;
  localparam int TIMEOUT = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NA-1:0] a;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic          found;
  logic [NF-1:0] i1;
  logic [NF-1:0] i2;

  factor_search_seq #(.NA(NA), .NF(NF)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .found(found), .i1(i1), .i2(i2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int found;
    int i1;
    int i2;
    int cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: scan divisors from 2 upward, cofactors 2..63, one search cycle per
  // candidate pair tried; a cofactor run stops once the product passes a.
  function automatic exp_t model(input int av);
    exp_t r;
    r.a = av; r.found = 0; r.i1 = 0; r.i2 = 0; r.cycles = 0;
    for (int dv = 2; dv < (1 << NF); dv++) begin
      for (int qv = 2; qv < (1 << NF); qv++) begin
        r.cycles++;
        if (dv * qv == av) begin
          r.found = 1; r.i1 = dv; r.i2 = qv;
          return r;
        end
        if (dv * qv > av) break;
      end
    end
    return r;
  endfunction

  // Monitor: counts SEARCH cycles, checks stability while stalled, scores handshakes.
  int   search_cnt = 0;
  bit   have_prev = 0;
  int   prev_found, prev_i1, prev_i2;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      search_cnt = 0;
      have_prev  = 0;
    end else begin
      if (busy && !out_valid) search_cnt++;
      if (out_valid) begin
        if (have_prev) begin
          check("stall_found_stable", int'(found), prev_found);
          check("stall_i1_stable", int'(i1), prev_i1);
          check("stall_i2_stable", int'(i2), prev_i2);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("found a=%0d", e.a), int'(found), e.found);
            check($sformatf("i1 a=%0d", e.a), int'(i1), e.i1);
            check($sformatf("i2 a=%0d", e.a), int'(i2), e.i2);
            check($sformatf("search_cycles a=%0d", e.a), search_cnt, e.cycles);
          end
          search_cnt = 0;
          have_prev  = 0;
        end else begin
          have_prev  = 1;
          prev_found = int'(found);
          prev_i1    = int'(i1);
          prev_i2    = int'(i2);
        end
      end
    end
  end

  task automatic check_idle(input string tag, input bit full);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    if (full) begin
      check({tag, "_found"}, int'(found), 0);
      check({tag, "_i1"}, int'(i1), 0);
      check({tag, "_i2"}, int'(i2), 0);
    end
  endtask

  // Called and returns at posedge+1. stall = cycles out_ready stays low after out_valid.
  task automatic run_one(input int av, input int stall);
    int waited;
    exp_q.push_back(model(av));
    a         = NA'(av);
    start     = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    a     = NA'($urandom);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < TIMEOUT);
    if (!out_valid) begin
      check($sformatf("timeout a=%0d", av), 0, 1);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      a     = NA'($urandom);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle($sformatf("post_handshake a=%0d", av), 1'b0);
    @(posedge clk); #1;
  endtask

  int rv;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset", 1'b1);
    @(posedge clk); #1;

    run_one(6, 0);
    run_one(0, 0);
    run_one(3969, 0);
    run_one(4093, 0);
    run_one(4095, 0);
    run_one(6, 5);

    // Abort in the 10th SEARCH cycle: no result may appear.
    a = NA'(4095); start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle("abort", 1'b1);
    @(posedge clk); #1;
    run_one(15, 0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 2 * $urandom_range(2, 63);
        1:       rv = 3 * $urandom_range(2, 63);
        default: rv = $urandom_range(0, 120);
      endcase
      run_one(rv, $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
